// File: rtl/latch_bank_arbiter_if.sv
// Bundle of request, data, latch-bank and status signals for latch_bank_arbiter.
// master: requesters plus the latch bank (drive Req/D/LatchQ).
// slave:  the arbiter (drives LatchEn/LatchD/Ack/Owner/Busy/Err).
interface latch_bank_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             Req0;
   logic             Req1;
   logic [WIDTH-1:0] D0;
   logic [WIDTH-1:0] D1;
   logic [WIDTH-1:0] LatchQ;
   logic             LatchEn;
   logic [WIDTH-1:0] LatchD;
   logic             Ack0;
   logic             Ack1;
   logic             Owner;
   logic             Busy;
   logic             Err;

   modport master (
      output Req0, Req1, D0, D1, LatchQ,
      input  LatchEn, LatchD, Ack0, Ack1, Owner, Busy, Err
   );

   modport slave (
      input  Req0, Req1, D0, D1, LatchQ,
      output LatchEn, LatchD, Ack0, Ack1, Owner, Busy, Err
   );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Two-requester round-robin arbiter driving a shared level-sensitive latch bank.
// Each write runs IDLE -> SETUP -> ENABLE (EN_CYCLES) -> HOLD -> DONE so the data
// bus is stable well before and after the enable pulse. All outputs are flops.
// Optional feature: define LATCH_VERIFY_EN to add a CHECK state that compares
// LatchQ against LatchD after HOLD and raises a sticky Err on mismatch.
module latch_bank_arbiter #(
   parameter int WIDTH     = 4,
   parameter int EN_CYCLES = 2
) (
   input  logic                Clk,
   input  logic                Rst_n,
   latch_bank_arbiter_if.slave bus
);

`ifdef LATCH_VERIFY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_ENABLE = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4,
      S_CHECK  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_ENABLE = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4
   } state_t;
`endif

   // Down-counter start value: ENABLE exits when the counter reads zero.
   localparam logic [3:0] CNT_LOAD = 4'(EN_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             last_q, last_d;         // requester served most recently
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] latch_d_q, latch_d_d;
   logic             latch_en_q, latch_en_d;
   logic [1:0]       ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             grant;
   logic             grant_owner;

   // State register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic, including arbitration while idle.
   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      grant_owner = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Req0 || bus.Req1) begin
               grant = 1'b1;
               // On contention the requester not served last wins.
               grant_owner = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
               state_d     = S_SETUP;
            end
         end
         S_SETUP:  state_d = S_ENABLE;
         S_ENABLE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_HOLD;
            end
         end
`ifdef LATCH_VERIFY_EN
         S_HOLD:   state_d = S_CHECK;
         S_CHECK:  state_d = S_DONE;
`else
         S_HOLD:   state_d = S_DONE;
`endif
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; outputs lag the state by one edge so they are flops.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_SETUP) begin
         cnt_d = CNT_LOAD;
      end else if ((state_q == S_ENABLE) && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end

      // Data and owner change only at grant, far from the enable pulse.
      owner_d   = owner_q;
      latch_d_d = latch_d_q;
      if (grant) begin
         owner_d   = grant_owner;
         latch_d_d = grant_owner ? bus.D1 : bus.D0;
      end

      last_d = last_q;
      if (state_q == S_DONE) begin
         last_d = owner_q;
      end

      latch_en_d = (state_q == S_ENABLE);

      ack_d = 2'b00;
      if (state_q == S_DONE) begin
         ack_d[owner_q] = 1'b1;
      end

      busy_d = (state_d != S_IDLE);
   end

   // Datapath and output registers; reset leaves the pointer favouring Req0.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q      <= 4'd0;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         latch_d_q  <= '0;
         latch_en_q <= 1'b0;
         ack_q      <= 2'b00;
         busy_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         latch_d_q  <= latch_d_d;
         latch_en_q <= latch_en_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

`ifdef LATCH_VERIFY_EN
   logic err_q, err_d;

   // Sticky readback mismatch detected while in CHECK.
   always_comb begin
      err_d = err_q | ((state_q == S_CHECK) && (bus.LatchQ != latch_d_q));
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.Err = err_q;
`else
   // Readback is not used without the verify feature.
   logic unused_latchq;
   assign unused_latchq = ^bus.LatchQ;
   assign bus.Err       = 1'b0;
`endif

   assign bus.LatchEn = latch_en_q;
   assign bus.LatchD  = latch_d_q;
   assign bus.Ack0    = ack_q[0];
   assign bus.Ack1    = ack_q[1];
   assign bus.Owner   = owner_q;
   assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: three instances (EN_CYCLES = 2, 1, 15) share one
// stimulus stream; each has a transaction-level model and a per-cycle compare.
module tb_latch_bank_arbiter;
   localparam int W = 4;
`ifdef LATCH_VERIFY_EN
   localparam int V = 1;
`else
   localparam int V = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] d0 = '0, d1 = '0;
   logic force_zero = 1'b0;

   int total = 0;
   int passed = 0;

   logic [2:0] en_w, ack0_w, ack1_w, owner_w, busy_w, err_w;
   logic [W-1:0] latchd_w [3];

   always #5 clk = ~clk;

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int EN = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);
      latch_bank_arbiter_if #(.WIDTH(W)) bus_i ();
      logic [W-1:0] lq = '0;

      assign bus_i.Req0   = req0;
      assign bus_i.Req1   = req1;
      assign bus_i.D0     = d0;
      assign bus_i.D1     = d1;
      assign bus_i.LatchQ = force_zero ? '0 : lq;

      // Behavioural transparent latch bank.
      always @(bus_i.LatchEn or bus_i.LatchD) if (bus_i.LatchEn) lq = bus_i.LatchD;

      latch_bank_arbiter #(.WIDTH(W), .EN_CYCLES(EN)) u_dut (
         .Clk  (clk),
         .Rst_n(rst_n),
         .bus  (bus_i)
      );

      assign en_w[gi]     = bus_i.LatchEn;
      assign ack0_w[gi]   = bus_i.Ack0;
      assign ack1_w[gi]   = bus_i.Ack1;
      assign owner_w[gi]  = bus_i.Owner;
      assign busy_w[gi]   = bus_i.Busy;
      assign err_w[gi]    = bus_i.Err;
      assign latchd_w[gi] = bus_i.LatchD;

      // Transaction model: a grant at edge g fixes the whole waveform of that write.
      int ecount = 0;
      int g = 0;
      int free_e = 0;
      bit have = 1'b0;
      logic m_owner = 1'b0;
      logic m_last = 1'b1;
      logic m_err = 1'b0;
      logic [W-1:0] m_data = '0;

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            have    <= 1'b0;
            m_owner <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b1;
            m_err   <= 1'b0;
            free_e  <= 0;
         end else begin
            ecount <= ecount + 1;
            if (V == 1 && have && (ecount + 1 == g + 3 + EN) && (bus_i.LatchQ != m_data))
               m_err <= 1'b1;
            if ((ecount + 1 >= free_e) && (req0 || req1)) begin
               have    <= 1'b1;
               g       <= ecount + 1;
               free_e  <= ecount + 1 + 4 + EN + V;
               m_owner <= (req0 && req1) ? ~m_last : req1;
               m_data  <= ((req0 && req1) ? ~m_last : req1) ? d1 : d0;
               m_last  <= (req0 && req1) ? ~m_last : req1;
            end
         end
      end

      // Per-cycle compare of every output against the model.
      always @(negedge clk) begin
         chk("LatchEn", gi, bus_i.LatchEn, have && ecount >= g + 2 && ecount <= g + 1 + EN);
         chk("LatchD",  gi, bus_i.LatchD, m_data);
         chk("Owner",   gi, bus_i.Owner, m_owner);
         chk("Ack0",    gi, bus_i.Ack0, have && ecount == g + 3 + EN + V && !m_owner);
         chk("Ack1",    gi, bus_i.Ack1, have && ecount == g + 3 + EN + V && m_owner);
         chk("Busy",    gi, bus_i.Busy, have && ecount <= g + 2 + EN + V);
         chk("Err",     gi, bus_i.Err, m_err);
         chk("AckExcl", gi, bus_i.Ack0 & bus_i.Ack1, 0);
         chk("EnAckExcl", gi, bus_i.LatchEn & (bus_i.Ack0 | bus_i.Ack1), 0);
      end
   end

   int en_cnt [3];
   int ack_at [3];
   int en_tab [3];
   bit ack1_any;
   int per;

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      en_tab[0] = 2; en_tab[1] = 1; en_tab[2] = 15;
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_LatchEn", 0, en_w[0], 0);
      chk("rst_LatchD", 0, latchd_w[0], 0);
      chk("rst_Owner", 0, owner_w[0], 0);
      chk("rst_Busy", 0, busy_w[0], 0);
      chk("rst_Ack0", 0, ack0_w[0], 0);
      chk("rst_Err", 0, err_w[0], 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request, also measures enable width and ack latency for all instances
      d0 = 4'hA; req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      ack1_any = 1'b0;
      for (int i = 0; i < 3; i++) begin en_cnt[i] = 0; ack_at[i] = -1; end
      for (int j = 0; j <= 22; j++) begin
         if (j == 0) begin
            chk("t1_LatchD", 0, latchd_w[0], 4'hA);
            chk("t1_Owner", 0, owner_w[0], 0);
            chk("t1_Busy", 0, busy_w[0], 1);
         end
         if (j >= 1 && j <= 4) chk("t1_LatchEn", 0, en_w[0], (j == 2 || j == 3));
         for (int i = 0; i < 3; i++) begin
            if (en_w[i]) en_cnt[i]++;
            if (ack0_w[i] && ack_at[i] < 0) ack_at[i] = j;
            if (ack1_w[i]) ack1_any = 1'b1;
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         chk("sweep_en_width", i, en_cnt[i], en_tab[i]);
         chk("sweep_ack_latency", i, ack_at[i], en_tab[i] + 3 + V);
      end
      chk("t1_no_ack1", 0, ack1_any, 0);

      // Contention: writes 3, C, 3, C with alternating owners and acks
      do_reset();
      per = 6 + V;
      d0 = 4'h3; d1 = 4'hC; req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      for (int j = 0; j <= 3 * per + 5 + V; j++) begin
         for (int k = 0; k < 4; k++) begin
            if (j == k * per) begin
               chk("t2_LatchD", 0, latchd_w[0], (k % 2 == 0) ? 4'h3 : 4'hC);
               chk("t2_Owner", 0, owner_w[0], k % 2);
            end
            if (j == k * per + 5 + V) begin
               chk("t2_Ack0", 0, ack0_w[0], (k % 2 == 0));
               chk("t2_Ack1", 0, ack1_w[0], (k % 2 == 1));
            end
         end
         @(negedge clk);
      end
      req0 = 1'b0; req1 = 1'b0;

      // Early drop: one-cycle Req1, data changed mid-write
      do_reset();
      d1 = 4'h5; req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
      for (int j = 0; j <= 6 + V; j++) begin
         if (j == 2) d1 = 4'hF;
         chk("t3_LatchD", 0, latchd_w[0], 4'h5);
         if (j == 0) chk("t3_Owner", 0, owner_w[0], 1);
         if (j == 5 + V) begin
            chk("t3_Ack1", 0, ack1_w[0], 1);
            chk("t3_Ack0", 0, ack0_w[0], 0);
         end
         @(negedge clk);
      end

      // Reset during the second ENABLE cycle
      do_reset();
      d0 = 4'h9; req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      chk("t4_LatchEn_before", 0, en_w[0], 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t4_LatchEn_async", 0, en_w[0], 0);
      chk("t4_Busy_async", 0, busy_w[0], 0);
      chk("t4_LatchD_async", 0, latchd_w[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      ack1_any = 1'b0;
      for (int j = 0; j < 10; j++) begin
         if (ack0_w[0]) ack1_any = 1'b1;
         @(negedge clk);
      end
      chk("t4_no_ack", 0, ack1_any, 0);
      d0 = 4'h7; d1 = 4'h8; req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      chk("t4_Owner", 0, owner_w[0], 0);
      chk("t4_LatchD", 0, latchd_w[0], 4'h7);
      repeat (22) @(negedge clk);

      // Readback mismatch (Err only meaningful with the verify feature)
      do_reset();
      force_zero = 1'b1; d0 = 4'h6; req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      for (int j = 0; j <= 7; j++) begin
         if (j == 5 + V) chk("t5_Ack0", 0, ack0_w[0], 1);
         @(negedge clk);
      end
      chk("t5_Err_set", 0, err_w[0], V);
      force_zero = 1'b0; d0 = 4'h2; req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      repeat (8) @(negedge clk);
      chk("t5_LatchD", 0, latchd_w[0], 4'h2);
      chk("t5_Err_sticky", 0, err_w[0], V);
      repeat (20) @(negedge clk);
      do_reset();
      chk("t5_Err_cleared", 0, err_w[0], 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/latch_bank_arbiter.md
LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, bit width of the shared latch data path.
REQ-002 Parameter EN_CYCLES, default 2, number of Clk cycles LatchEn is held high per write; legal range is 1..15.
REQ-003 Port Clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 Port Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port Req0 / Req1  input  1 each  write request from requester 0 / 1.
REQ-006 Port D0 / D1  input  WIDTH each  write data from requester 0 / 1.
REQ-007 Port LatchQ  input  WIDTH  Q outputs of the shared latch bank; used only under LATCH_VERIFY_EN.
REQ-008 Port LatchEn  output  1  enable to the shared latch bank.
REQ-009 Port LatchD  output  WIDTH  data to the shared latch bank.
REQ-010 Port Ack0 / Ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-011 Port Owner  output  1  index of the requester currently being served.
REQ-012 Port Busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 Port Err  output  1  sticky readback-mismatch flag.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, ENABLE, HOLD and DONE, plus CHECK under LATCH_VERIFY_EN.
REQ-015 All outputs SHALL be registered; no output SHALL be combinational from any input.
REQ-016 In IDLE with only one request high at a rising edge, that requester SHALL be granted.
REQ-017 In IDLE with both requests high, the requester not served last SHALL be granted (round-robin pointer).
REQ-018 On grant, Owner SHALL be set, the winner's D SHALL be captured into LatchD, and the FSM SHALL go to SETUP.
REQ-019 SETUP SHALL last exactly 1 cycle with LatchEn=0 and LatchD stable, then go to ENABLE.
REQ-020 ENABLE SHALL hold LatchEn=1 for exactly EN_CYCLES cycles, counted by an internal down-counter, then go to HOLD.
REQ-021 HOLD SHALL last 1 cycle with LatchEn=0 and LatchD unchanged, then go to DONE (or to CHECK when the macro is defined).
REQ-022 DONE SHALL assert Ack[Owner] for exactly 1 cycle, update the round-robin pointer to Owner, and then return to IDLE.
REQ-023 Latency: for a grant at edge k, LatchEn SHALL be high from edge k+2 to edge k+2+EN_CYCLES, and Ack SHALL be high for the cycle after edge k+3+EN_CYCLES (one cycle later under the macro).
REQ-024 LatchD SHALL change only at grant; it SHALL never change while LatchEn=1 or within one cycle either side of LatchEn=1.
REQ-025 Requests SHALL be ignored outside IDLE; a Req that drops after grant SHALL NOT abort the transaction, and its Ack SHALL still pulse.
REQ-026 A Req still high in the IDLE cycle after its Ack SHALL be treated as a new request.
REQ-027 Two continuously asserted requests SHALL be served strictly alternately.
REQ-028 At most one of Ack0/Ack1 SHALL be high in any cycle.
REQ-029 At most one of LatchEn and any Ack SHALL be high in any cycle.

Reset
REQ-030 Rst_n=0 SHALL immediately, without waiting for Clk, force the following: state IDLE, LatchEn=0, LatchD=0, Ack0=Ack1=0, Owner=0, Busy=0, Err=0, counter=0.
REQ-031 After reset, the round-robin pointer SHALL favour Req0 on a first simultaneous request.
REQ-032 Reset during ENABLE SHALL drop LatchEn asynchronously, and no Ack SHALL be issued for the aborted write.
REQ-033 The first grant after reset release SHALL occur no earlier than the first rising edge at which Rst_n is sampled high.

Configuration
REQ-034 Macro LATCH_VERIFY_EN, when defined, SHALL insert a 1-cycle CHECK state between HOLD and DONE.
REQ-035 In CHECK, if LatchQ != LatchD, Err SHALL be set and SHALL stay high until reset; DONE and Ack SHALL still follow.
REQ-036 When LATCH_VERIFY_EN is undefined, CHECK SHALL not exist, LatchQ SHALL be ignored, and Err SHALL be constant 0.

Verification
REQ-037 Single request: Req0=1, D0=4'hA, EN_CYCLES=2, grant at edge k -> LatchD=A at k+1; LatchEn high for edges k+2..k+4; Ack0 after edge k+5; Ack1 stays 0.
REQ-038 Contention: Req0=Req1=1 held, D0=3, D1=C after reset -> writes in the order 3, C, 3, C; Ack0 and Ack1 alternate; Owner toggles 0,1,0,1.
REQ-039 Early drop: Req1 pulsed for 1 cycle with D1=5 -> complete write of 5 and an Ack1 pulse; D1 changed to F during ENABLE does not alter LatchD.
REQ-040 Reset mid-write: Rst_n low during the second ENABLE cycle -> LatchEn=0 within the same cycle; no Ack; Busy=0; next simultaneous request grants Req0.
REQ-041 With LATCH_VERIFY_EN: LatchQ forced to 0 while D0=6 -> Err=1 after CHECK, Ack0 still pulses, Err stays 1 through later correct writes until Rst_n=0.
REQ-042 Parameter sweep: EN_CYCLES=1 and EN_CYCLES=15 -> LatchEn high for exactly 1 and 15 cycles respectively, with Ack latency matching REQ-023.
